// File: rtl/chiplet_rc_vc_unit.sv
// Per-VC registered dimension-order route computation for a chiplet input port.
// Each VC holds one route per in-flight packet, from head capture until tail release.
module chiplet_rc_vc_unit #(
    parameter int unsigned X_CURRENT        = 0,
    parameter int unsigned Y_CURRENT        = 0,
    parameter int unsigned DEST_ADDR_SIZE_X = 4,
    parameter int unsigned DEST_ADDR_SIZE_Y = 4,
    parameter int unsigned MESH_SIZE_X      = 4,
    parameter int unsigned MESH_SIZE_Y      = 4,
    parameter int unsigned VC_NUM           = 2,
    parameter int unsigned ROUTING_MODE     = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [VC_NUM-1:0]                      head_valid_i,
    input  logic [VC_NUM-1:0][DEST_ADDR_SIZE_X-1:0] x_dest_i,
    input  logic [VC_NUM-1:0][DEST_ADDR_SIZE_Y-1:0] y_dest_i,
    input  logic [VC_NUM-1:0]                      tail_done_i,
    output logic [VC_NUM-1:0]                      head_ready_o,
    output logic [VC_NUM-1:0]                      route_valid_o,
    output logic [VC_NUM-1:0][2:0]                 route_o,
    output logic [VC_NUM-1:0]                      dest_err_o
);

    // Output port encoding
    localparam logic [2:0] PortLocal = 3'd0;
    localparam logic [2:0] PortEast  = 3'd1;
    localparam logic [2:0] PortWest  = 3'd2;
    localparam logic [2:0] PortNorth = 3'd3;
    localparam logic [2:0] PortSouth = 3'd4;

    localparam int unsigned DxW = DEST_ADDR_SIZE_X + 1;
    localparam int unsigned DyW = DEST_ADDR_SIZE_Y + 1;

    localparam logic [DxW-1:0] XCur  = DxW'(X_CURRENT);
    localparam logic [DyW-1:0] YCur  = DyW'(Y_CURRENT);
    localparam logic [DxW-1:0] MeshX = DxW'(MESH_SIZE_X);
    localparam logic [DyW-1:0] MeshY = DyW'(MESH_SIZE_Y);

    typedef enum logic {StIdle, StRouted} state_e;

    state_e                 state_q [VC_NUM];
    state_e                 state_d [VC_NUM];
    logic [VC_NUM-1:0][2:0] route_q, route_d;
    logic [VC_NUM-1:0]      err_q, err_d;

    function automatic logic out_of_range(input logic [DEST_ADDR_SIZE_X-1:0] x,
                                          input logic [DEST_ADDR_SIZE_Y-1:0] y);
        return ({1'b0, x} >= MeshX) || ({1'b0, y} >= MeshY);
    endfunction

    function automatic logic [2:0] calc_route(input logic [DEST_ADDR_SIZE_X-1:0] x,
                                              input logic [DEST_ADDR_SIZE_Y-1:0] y);
        logic signed [DxW-1:0] dx;
        logic signed [DyW-1:0] dy;
        logic [2:0]            rx;
        logic [2:0]            ry;
        dx = $signed({1'b0, x}) - $signed(XCur);
        dy = $signed({1'b0, y}) - $signed(YCur);
        rx = PortLocal;
        ry = PortLocal;
        if (dx[DxW-1])      rx = PortWest;
        else if (dx != '0)  rx = PortEast;
        // Y grows downwards, so a smaller Y lies to the north
        if (dy[DyW-1])      ry = PortNorth;
        else if (dy != '0)  ry = PortSouth;
        if (ROUTING_MODE == 0) return (rx != PortLocal) ? rx : ry;
        else                   return (ry != PortLocal) ? ry : rx;
    endfunction

    always_comb begin
        route_d = route_q;
        err_d   = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            // A tail in the same cycle frees the VC for a back-to-back head
            if (head_valid_i[v] && (state_q[v] == StIdle || tail_done_i[v])) begin
                state_d[v] = StRouted;
                err_d[v]   = out_of_range(x_dest_i[v], y_dest_i[v]);
                route_d[v] = err_d[v] ? PortLocal : calc_route(x_dest_i[v], y_dest_i[v]);
            end else if (state_q[v] == StRouted && tail_done_i[v]) begin
                state_d[v] = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= StIdle;
            end
            route_q <= {VC_NUM{PortLocal}};
            err_q   <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
            end
            route_q <= route_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        head_ready_o  = '0;
        route_valid_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            head_ready_o[v]  = (state_q[v] == StIdle);
            route_valid_o[v] = (state_q[v] == StRouted);
        end
    end

    assign route_o    = route_q;
    assign dest_err_o = err_q;

endmodule
